// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front-end.
//   spi_state_t   - frame state machine encoding
//   CMD_*         - 2-bit command codes carried in the top bits of each frame
//   is_read_data  - helper: does this command request read data from the slave
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    WAIT_TX,
    TX,
    DONE
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic is_read_data(input logic [1:0] cmd);
    return cmd == CMD_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_slave_mode_if_if.sv
// spi_slave_mode_if_if: parallel-side bus between the SPI slave and the
// register/RAM controller.
//   rx_data   - last complete frame, command in the two MSBs
//   rx_valid  - one-clk pulse when rx_data updates
//   tx_ready  - slave is waiting for read data
//   tx_valid  - tx_data is valid (controller side)
//   tx_data   - read data to shift out
//   frame_err - one-clk pulse on an aborted frame
// Modports: slave = the SPI block, master = the controller driving it.
interface spi_slave_mode_if_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              tx_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              frame_err;

  modport slave (
    output rx_data, rx_valid, tx_ready, frame_err,
    input  tx_valid, tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_ready, frame_err,
    output tx_valid, tx_data
  );

endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: brings sclk/ss_n/mosi into the clk domain and turns sclk
// transitions into one-clk sample/shift pulses for the selected SPI mode.
//   clk, rst_n    - system clock, async active-low reset
//   sclk, ss_n,
//   mosi          - raw SPI pins (asynchronous)
//   ss_n_s        - synchronised slave select
//   mosi_s        - synchronised mosi, aligned with sample_pulse
//   sample_pulse  - one-clk pulse on the mode's sample edge
//   shift_pulse   - one-clk pulse on the mode's shift edge
module spi_edge_sync #(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic ss_n_s,
  output logic mosi_s,
  output logic sample_pulse,
  output logic shift_pulse
);

  localparam logic IDLE_LVL = (CPOL != 0);
  localparam int   MSB      = SYNC_STAGES - 1;

  logic [MSB:0] sclk_sync_reg;
  logic [MSB:0] ss_n_sync_reg;
  logic [MSB:0] mosi_sync_reg;
  logic         sclk_prev_reg;
  logic         lead_reg;
  logic         trail_reg;
  logic         mosi_dly_reg;

  // The synchronisers reset to the pins' idle levels (sclk at CPOL, ss_n
  // deselected) so that leaving reset never looks like an edge or a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= {SYNC_STAGES{IDLE_LVL}};
      ss_n_sync_reg <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= IDLE_LVL;
      lead_reg      <= 1'b0;
      trail_reg     <= 1'b0;
      mosi_dly_reg  <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[MSB-1:0], sclk};
      ss_n_sync_reg <= {ss_n_sync_reg[MSB-1:0], ss_n};
      mosi_sync_reg <= {mosi_sync_reg[MSB-1:0], mosi};
      sclk_prev_reg <= sclk_sync_reg[MSB];
      // Pulses are registered, giving SYNC_STAGES+1 clk pin-to-pulse latency.
      lead_reg      <= (sclk_sync_reg[MSB] != IDLE_LVL) && (sclk_prev_reg == IDLE_LVL);
      trail_reg     <= (sclk_sync_reg[MSB] == IDLE_LVL) && (sclk_prev_reg != IDLE_LVL);
      // Delay mosi by the same extra stage so it lines up with the pulses.
      mosi_dly_reg  <= mosi_sync_reg[MSB];
    end
  end

  assign ss_n_s       = ss_n_sync_reg[MSB];
  assign mosi_s       = mosi_dly_reg;
  assign sample_pulse = (CPHA != 0) ? trail_reg : lead_reg;
  assign shift_pulse  = (CPHA != 0) ? lead_reg  : trail_reg;

endmodule

// File: rtl/spi_slave_mode_if.sv
// spi_slave_mode_if: oversampled SPI slave front-end, all four CPOL/CPHA
// modes. Frame = 2-bit command + DATA_W payload, MSB first. A read-data
// command (11) pauses for tx data from the controller, then shifts it out.
//   clk, rst_n       - system clock (>= 4x SCLK), async active-low reset
//   sclk, ss_n, mosi - SPI pins from the master
//   miso, miso_oe    - serial read data and its output enable
//   bus (slave)      - rx_data/rx_valid, tx_ready/tx_valid/tx_data, frame_err
module spi_slave_mode_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  spi_slave_mode_if_if.slave   bus
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W - 1);

  logic ss_n_s;
  logic mosi_s;
  logic sample_pulse;
  logic shift_pulse;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .ss_n         (ss_n),
    .mosi         (mosi),
    .ss_n_s       (ss_n_s),
    .mosi_s       (mosi_s),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse)
  );

  spi_state_t          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [FRAME_W-2:0]  rx_sr_reg;   // bits received so far; the last bit goes straight to rx_data
  logic [DATA_W-1:0]   tx_sr_reg;
  logic [FRAME_W-1:0]  rx_data_reg;
  logic                rx_valid_reg;
  logic                tx_ready_reg;
  logic                miso_oe_reg;
  logic                frame_err_reg;
  logic                skip_reg;    // CPHA=1: first shift edge in TX is already covered by the entry bit

  logic [FRAME_W-1:0]  rx_frame_next;
  logic                abort;

  assign rx_frame_next = {rx_sr_reg, mosi_s};
  // ss_n release has priority over any same-cycle sample edge.
  assign abort = ss_n_s && (state_reg inside {RX, WAIT_TX, TX});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rx_sr_reg     <= '0;
      tx_sr_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      tx_ready_reg  <= 1'b0;
      miso_oe_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      skip_reg      <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (abort) begin
        state_reg     <= IDLE;
        frame_err_reg <= 1'b1;
        tx_ready_reg  <= 1'b0;
        miso_oe_reg   <= 1'b0;
        tx_sr_reg     <= '0;
        cnt_reg       <= '0;
        skip_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!ss_n_s) begin
              state_reg <= RX;
              cnt_reg   <= '0;
              rx_sr_reg <= '0;
            end
          end
          RX: begin
            if (sample_pulse) begin
              rx_sr_reg <= rx_frame_next[FRAME_W-2:0];
              if (cnt_reg == LAST_RX) begin
                rx_data_reg  <= rx_frame_next;
                rx_valid_reg <= 1'b1;
                cnt_reg      <= '0;
                if (is_read_data(rx_frame_next[FRAME_W-1 -: 2])) begin
                  state_reg    <= WAIT_TX;
                  tx_ready_reg <= 1'b1;
                end else begin
                  state_reg <= DONE;
                end
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          WAIT_TX: begin
            if (bus.tx_valid && tx_ready_reg) begin
              tx_sr_reg    <= bus.tx_data;
              tx_ready_reg <= 1'b0;
              miso_oe_reg  <= 1'b1;
              skip_reg     <= (CPHA != 0);
              state_reg    <= TX;
            end
          end
          TX: begin
            if (shift_pulse) begin
              if (skip_reg) begin
                skip_reg <= 1'b0;
              end else begin
                tx_sr_reg <= {tx_sr_reg[DATA_W-2:0], 1'b0};
              end
            end
            if (sample_pulse) begin
              if (cnt_reg == LAST_TX) begin
                state_reg   <= DONE;
                miso_oe_reg <= 1'b0;
                cnt_reg     <= '0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          DONE: begin
            if (ss_n_s) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // miso is decoded directly so the first bit appears the cycle TX is entered.
  assign miso          = (state_reg == TX) ? tx_sr_reg[DATA_W-1] : 1'b0;
  assign miso_oe       = miso_oe_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.tx_ready  = tx_ready_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_mode_if.sv
// tb_spi_slave_mode_if: one DUT per SPI mode (index = {CPOL,CPHA}), driven
// by a bench-side SPI master. Table-driven frames plus hand-written abort,
// DONE-overrun and reset sequences; rx frames go through a scoreboard.
module tb_spi_slave_mode_if;

  localparam int DW = 8;
  localparam int H  = 8;   // SCLK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          sclk_a[4], ss_n_a[4], mosi_a[4], miso_a[4], miso_oe_a[4];
  logic          tx_valid_a[4], rx_valid_a[4], tx_ready_a[4], frame_err_a[4];
  logic [DW-1:0] tx_data_a[4];
  logic [DW+1:0] rx_data_a[4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    spi_slave_mode_if_if #(.DATA_W(DW)) bus ();
    assign bus.tx_valid    = tx_valid_a[gi];
    assign bus.tx_data     = tx_data_a[gi];
    assign rx_data_a[gi]   = bus.rx_data;
    assign rx_valid_a[gi]  = bus.rx_valid;
    assign tx_ready_a[gi]  = bus.tx_ready;
    assign frame_err_a[gi] = bus.frame_err;
    spi_slave_mode_if #(
      .DATA_W(DW), .CPOL(gi / 2), .CPHA(gi % 2), .SYNC_STAGES(2)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sclk    (sclk_a[gi]),
      .ss_n    (ss_n_a[gi]),
      .mosi    (mosi_a[gi]),
      .miso    (miso_a[gi]),
      .miso_oe (miso_oe_a[gi]),
      .bus     (bus)
    );
  end

  // ---------------- monitor: counts events, records observed frames -------
  int            rxv_cnt[4]  = '{default: 0};
  int            ferr_cnt[4] = '{default: 0};
  int            oe_cnt[4]   = '{default: 0};
  int            viol_cnt[4] = '{default: 0};
  logic [DW+1:0] obs_data[256];
  int            obs_mode[256];
  int            obs_n = 0;

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_a[m] === 1'b1) begin
        rxv_cnt[m] <= rxv_cnt[m] + 1;
        if (obs_n < 256) begin
          obs_data[obs_n] <= rx_data_a[m];
          obs_mode[obs_n] <= m;
          obs_n           <= obs_n + 1;
        end
        $display("[%0t] mode %0d rx_valid rx_data=%h", $time, m, rx_data_a[m]);
      end
      if (frame_err_a[m] === 1'b1) begin
        ferr_cnt[m] <= ferr_cnt[m] + 1;
        $display("[%0t] mode %0d frame_err", $time, m);
      end
      if (miso_oe_a[m] === 1'b1) oe_cnt[m] <= oe_cnt[m] + 1;
      // miso must be quiet whenever it is not enabled, and an abort drops oe at once.
      if ((miso_oe_a[m] !== 1'b1 && miso_a[m] !== 1'b0) ||
          (frame_err_a[m] === 1'b1 && miso_oe_a[m] !== 1'b0))
        viol_cnt[m] <= viol_cnt[m] + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int            mode;
    logic [DW+1:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   obs_rd = 0;
  logic [DW+1:0] last_rx[4];

  task automatic sb_push(input int m, input logic [DW+1:0] d);
    exp_t e;
    e.mode = m;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (obs_rd < obs_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_rx: got %h from mode %0d expected nothing",
                 obs_data[obs_rd], obs_mode[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        chk("sb_mode", obs_mode[obs_rd], e.mode);
        chk("sb_rx_data", 32'(obs_data[obs_rd]), 32'(e.data));
      end
      obs_rd++;
    end
    chk("sb_missing_rx", exp_q.size(), 0);
  endtask

  // ---------------- SPI master ----------------
  task automatic clock_bits(input int m, input int n, input logic [15:0] bout,
                            output logic [15:0] bin, output logic oe_all);
    logic cpol, cpha;
    cpol   = (m >= 2);
    cpha   = (m % 2 == 1);
    bin    = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi_a[m] = bout[n-1-i];
        wait_clk(H);
        bin    = {bin[14:0], miso_a[m]};
        oe_all = oe_all & miso_oe_a[m];
        sclk_a[m] = ~cpol;
        wait_clk(H);
        sclk_a[m] = cpol;
      end else begin
        sclk_a[m] = ~cpol;
        mosi_a[m] = bout[n-1-i];
        wait_clk(H);
        bin    = {bin[14:0], miso_a[m]};
        oe_all = oe_all & miso_oe_a[m];
        sclk_a[m] = cpol;
        wait_clk(H);
      end
    end
    if (!cpha) wait_clk(H);
  endtask

  // Waits for tx_ready (bounded), then hands tx over for one clk.
  task automatic give_tx(input int m, input logic [DW-1:0] d);
    int waited;
    waited = 0;
    while (tx_ready_a[m] !== 1'b1 && waited < 40) begin
      wait_clk(1);
      waited++;
    end
    chk("tx_ready_wait", tx_ready_a[m], 1);
    chk("oe_before_tx", miso_oe_a[m], 0);
    tx_data_a[m]  = d;
    tx_valid_a[m] = 1'b1;
    wait_clk(1);
    tx_valid_a[m] = 1'b0;
    wait_clk(2);
    chk("tx_ready_drop", tx_ready_a[m], 0);
    chk("oe_in_tx", miso_oe_a[m], 1);
  endtask

  typedef struct {
    int            mode;
    logic [DW+1:0] frame;
    logic          rd;
    logic [DW-1:0] tx;
    logic [DW+1:0] exp_rx;
    logic [DW-1:0] exp_byte;
  } vec_t;
  vec_t vecs[9];

  task automatic run_frame(input vec_t v);
    int m, r0, f0, o0, x0;
    logic [15:0] bin;
    logic oe_all;
    m  = v.mode;
    r0 = rxv_cnt[m];
    f0 = ferr_cnt[m];
    o0 = oe_cnt[m];
    x0 = viol_cnt[m];
    sb_push(m, v.exp_rx);
    $display("[%0t] mode %0d frame %h rd=%0b", $time, m, v.frame, v.rd);
    ss_n_a[m] = 1'b0;
    wait_clk(4);
    clock_bits(m, DW + 2, 16'(v.frame), bin, oe_all);
    if (v.rd) begin
      give_tx(m, v.tx);
      wait_clk(8);
      clock_bits(m, DW, 16'h0, bin, oe_all);
      $display("[%0t] mode %0d master read %h", $time, m, bin[DW-1:0]);
      chk("miso_byte", 32'(bin[DW-1:0]), 32'(v.exp_byte));
      chk("oe_all_tx_bits", oe_all, 1);
      wait_clk(6);
      chk("oe_after_tx", miso_oe_a[m], 0);
    end else begin
      wait_clk(6);
    end
    ss_n_a[m] = 1'b1;
    wait_clk(4);
    sb_drain();
    chk("rx_valid_count", rxv_cnt[m] - r0, 1);
    chk("frame_err_count", ferr_cnt[m] - f0, 0);
    if (!v.rd) chk("oe_write_frame", oe_cnt[m] - o0, 0);
    chk("miso_oe_violations", viol_cnt[m] - x0, 0);
    last_rx[m] = v.exp_rx;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, o0, x0;
    logic [15:0] bin;
    logic oe_all;

    vecs[0] = '{0, 10'h0A5, 1'b0, 8'h00, 10'h0A5, 8'h00};
    vecs[1] = '{0, 10'h35A, 1'b1, 8'hC3, 10'h35A, 8'hC3};
    vecs[2] = '{1, 10'h35A, 1'b1, 8'hC3, 10'h35A, 8'hC3};
    vecs[3] = '{2, 10'h35A, 1'b1, 8'hC3, 10'h35A, 8'hC3};
    vecs[4] = '{3, 10'h35A, 1'b1, 8'hC3, 10'h35A, 8'hC3};
    vecs[5] = '{0, 10'h1FF, 1'b0, 8'h00, 10'h1FF, 8'h00};
    vecs[6] = '{0, 10'h200, 1'b0, 8'h00, 10'h200, 8'h00};
    vecs[7] = '{3, 10'h16C, 1'b0, 8'h00, 10'h16C, 8'h00};
    vecs[8] = '{2, 10'h3F0, 1'b1, 8'h81, 10'h3F0, 8'h81};

    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sclk_a[m]     = (m >= 2);
      ss_n_a[m]     = 1'b1;
      mosi_a[m]     = 1'b0;
      tx_valid_a[m] = 1'b0;
      tx_data_a[m]  = '0;
      last_rx[m]    = '0;
    end
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      chk("reset_rx_data", 32'(rx_data_a[m]), 0);
      chk("reset_rx_valid", rx_valid_a[m], 0);
      chk("reset_tx_ready", tx_ready_a[m], 0);
      chk("reset_frame_err", frame_err_a[m], 0);
      chk("reset_miso", miso_a[m], 0);
      chk("reset_miso_oe", miso_oe_a[m], 0);
    end
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // Abort in RX after 6 bits (mode 0).
    r0 = rxv_cnt[0]; f0 = ferr_cnt[0]; x0 = viol_cnt[0];
    $display("[%0t] mode 0 abort after 6 rx bits", $time);
    ss_n_a[0] = 1'b0;
    wait_clk(4);
    clock_bits(0, 6, 16'h2A, bin, oe_all);
    ss_n_a[0] = 1'b1;
    wait_clk(8);
    chk("rx_abort_frame_err", ferr_cnt[0] - f0, 1);
    chk("rx_abort_no_rx_valid", rxv_cnt[0] - r0, 0);
    chk("rx_abort_rx_data_kept", 32'(rx_data_a[0]), 32'(last_rx[0]));
    chk("rx_abort_violations", viol_cnt[0] - x0, 0);
    sb_drain();

    // Abort in TX after 3 bits (mode 1); the command frame itself completes.
    r0 = rxv_cnt[1]; f0 = ferr_cnt[1]; x0 = viol_cnt[1];
    $display("[%0t] mode 1 abort after 3 tx bits", $time);
    sb_push(1, 10'h3C3);
    ss_n_a[1] = 1'b0;
    wait_clk(4);
    clock_bits(1, DW + 2, 16'h3C3, bin, oe_all);
    give_tx(1, 8'hA5);
    wait_clk(8);
    clock_bits(1, 3, 16'h0, bin, oe_all);
    chk("tx_abort_first_bits", 32'(bin[2:0]), 32'h5);
    ss_n_a[1] = 1'b1;
    wait_clk(8);
    chk("tx_abort_frame_err", ferr_cnt[1] - f0, 1);
    chk("tx_abort_rx_valid", rxv_cnt[1] - r0, 1);
    chk("tx_abort_oe", miso_oe_a[1], 0);
    chk("tx_abort_violations", viol_cnt[1] - x0, 0);
    sb_drain();
    last_rx[1] = 10'h3C3;
    run_frame(vecs[2]);

    // tx_valid in IDLE and RX is ignored; extra clocks in DONE are harmless.
    r0 = rxv_cnt[0]; f0 = ferr_cnt[0]; o0 = oe_cnt[0];
    $display("[%0t] mode 0 tx_valid in IDLE/RX, 12 extra bits in DONE", $time);
    tx_data_a[0]  = 8'hFF;
    tx_valid_a[0] = 1'b1;
    wait_clk(2);
    chk("idle_tx_ready", tx_ready_a[0], 0);
    sb_push(0, 10'h155);
    ss_n_a[0] = 1'b0;
    wait_clk(4);
    clock_bits(0, DW + 2, 16'h155, bin, oe_all);
    chk("rx_tx_ready", tx_ready_a[0], 0);
    tx_valid_a[0] = 1'b0;
    clock_bits(0, 12, 16'hABC, bin, oe_all);
    wait_clk(6);
    ss_n_a[0] = 1'b1;
    wait_clk(4);
    chk("done_rx_valid_count", rxv_cnt[0] - r0, 1);
    chk("done_frame_err", ferr_cnt[0] - f0, 0);
    chk("done_oe_cycles", oe_cnt[0] - o0, 0);
    sb_drain();
    last_rx[0] = 10'h155;

    // Reset mid-TX (mode 3): outputs clear asynchronously.
    $display("[%0t] mode 3 reset during tx", $time);
    sb_push(3, 10'h3E7);
    ss_n_a[3] = 1'b0;
    wait_clk(4);
    clock_bits(3, DW + 2, 16'h3E7, bin, oe_all);
    give_tx(3, 8'h5A);
    wait_clk(8);
    clock_bits(3, 3, 16'h0, bin, oe_all);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_miso", miso_a[3], 0);
    chk("rst_miso_oe", miso_oe_a[3], 0);
    chk("rst_tx_ready", tx_ready_a[3], 0);
    chk("rst_rx_valid", rx_valid_a[3], 0);
    chk("rst_frame_err", frame_err_a[3], 0);
    chk("rst_rx_data", 32'(rx_data_a[3]), 0);
    ss_n_a[3] = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    sb_drain();
    last_rx[3] = '0;
    run_frame(vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_mode_if.md
Name: spi_slave_mode_if

Overview:
Parametrised SPI slave front-end, the successor of the existing single-mode slave interface.
- Oversamples an external SCLK on the system clock and supports all four CPOL/CPHA modes.
- Payload width is generic; the frame is a 2-bit command followed by DATA_W bits.
- Adds a tx_ready handshake for read data, abort detection on early SS_N release, and a MISO output-enable.
- Sits between the SPI pins and the register/RAM controller.

Parameters:
DATA_W, 8, payload width; frame length is DATA_W+2 bits.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
SYNC_STAGES, 2, synchroniser depth for sclk/ss_n/mosi; legal range is 2 or more.

Ports:
clk  in  1  system clock; must be at least 4x the SCLK frequency.
rst_n  in  1  asynchronous, active-low reset.
sclk  in  1  SPI clock (asynchronous to clk).
ss_n  in  1  slave select, active low (asynchronous).
mosi  in  1  serial data in, MSB first.
miso  out  1  serial data out, MSB first; 0 when miso_oe=0.
miso_oe  out  1  high only while the block drives read data.
rx_data  out  DATA_W+2  last complete frame; bits [DATA_W+1:DATA_W] hold the command.
rx_valid  out  1  one-clk pulse when rx_data is updated.
tx_ready  out  1  block is waiting for read data.
tx_valid  in  1  tx_data valid.
tx_data  in  DATA_W  read data to shift out.
frame_err  out  1  one-clk pulse on aborted frame.

Behaviour:
Reset values:
- Asynchronous reset: state=IDLE, all shift registers and counters 0.
- Outputs after reset: miso=0, miso_oe=0, rx_valid=0, tx_ready=0, frame_err=0, rx_data=0.

Synchronisation and edge detection:
- sclk, ss_n and mosi each pass through SYNC_STAGES flops.
- Leading edge = synced sclk leaving the CPOL level; trailing edge = returning to it. Each is a one-clk pulse.
- Sample edge = leading if CPHA=0, else trailing. Shift edge = the opposite edge.
- Latency from a pin edge to the internal pulse is SYNC_STAGES+1 clk.

Command codes:
- 00 write address, 01 write data, 10 read address, 11 read data.

State machine (IDLE, RX, WAIT_TX, TX, DONE):
- IDLE: synced ss_n low -> RX, bit counter cleared. All sclk edges are ignored in IDLE.
- RX: each sample edge shifts mosi into rx_sr LSB (MSB-first frame) and increments the counter.
  - At count DATA_W+2: rx_data<=rx_sr, and rx_valid pulses on the next clk.
  - Command 11 -> WAIT_TX; any other command -> DONE.
- WAIT_TX: tx_ready=1. On tx_valid&&tx_ready, tx_sr<=tx_data and -> TX.
  - tx_valid outside WAIT_TX is ignored.
  - SCLK edges during WAIT_TX are ignored; the master must leave a gap of at least 8 clk.
- TX: miso_oe=1 and miso=tx_sr[DATA_W-1].
  - The first bit is presented on entry to TX.
  - Each shift edge shifts tx_sr left, filling with 0. With CPHA=1 the first shift edge in TX is skipped.
  - After DATA_W sample edges -> DONE.
- DONE: waits for synced ss_n high -> IDLE. Extra sclk edges are ignored. No error is raised.

Abort:
- Synced ss_n high in RX, WAIT_TX or TX -> frame_err pulses for 1 clk and the FSM goes to IDLE.
- On abort: no rx_valid, rx_data is unchanged, tx_sr is cleared, miso_oe drops on the same cycle.

Simultaneous events:
- ss_n rising in the same clk as the final sample edge: abort wins, so no rx_valid.
- tx_valid in the same clk as entry into WAIT_TX is accepted on the next clk, because tx_ready is registered high only from the first WAIT_TX cycle.

Other rules:
- All outputs are registered except miso, which is a direct decode of tx_sr and state.
- The counter is $clog2(DATA_W+3) bits wide and cannot wrap inside a frame.

Decomposition:
- Package spi_pkg holds:
  - the state enum spi_state_t {IDLE, RX, WAIT_TX, TX, DONE};
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module spi_edge_sync: parametrised synchroniser plus edge detector. Takes CPOL and CPHA; outputs synced ss_n, synced mosi, sample_pulse and shift_pulse.

Test Plan:
1. Mode 0, DATA_W=8, frame 00_1010_0101 -> one rx_valid pulse, rx_data=10'h0A5, miso_oe stays 0, state returns to IDLE after ss_n rises.
2. All four modes: command 11 frame, then tx_data=8'hC3 with tx_valid during tx_ready -> master samples 8'hC3 MSB first on its sample edges, and miso_oe is high only during TX.
3. Abort: ss_n raised after 6 bits of RX, and separately after 3 TX bits -> frame_err pulses once, no rx_valid, miso_oe=0 the same clk, the next full frame is received correctly.
4. Back-to-back frames, with ss_n high for 4 clk between them, using 01_FF then 10_00 -> two rx_valid pulses with rx_data 10'h1FF and 10'h200.
5. tx_valid pulsed in IDLE and RX -> ignored, tx_ready=0; 12 extra SCLK bits after a write frame (DONE state) -> no rx_valid, no error.
6. rst_n asserted mid-TX -> all outputs 0 immediately (asynchronously); after release, state is IDLE and the next frame works normally.
